toothless_muldiv: RTL and testbench
===================================

# toothless_muldiv

Iterative RV32M multiply/divide unit for the toothless core. It sits beside the ALU in the execute stage and accepts one operation at a time through a valid/ready handshake. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a radix-2 shift-add / restoring-divide datapath parametrised in operand width. The result is held until the consumer accepts it; a flush input aborts an operation in flight.

## Interface
Parameters:
- XLEN, 32, operand/result width; must be a power of two, ≥ 8.
- EARLY_OUT, 1, when 1, divide-by-zero and signed-overflow divides bypass iteration.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request; high only in IDLE.
- op_i  in  3  md_opcode_e; encoding equals RV32M funct3.
- a_i  in  XLEN  operand rs1.
- b_i  in  XLEN  operand rs2.
- flush_i  in  1  abort current operation; highest priority after reset.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  result; registered.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i: latch op, operand magnitudes, sign flags, clear counter.
  - Go to CALC, or to DONE directly for an EARLY_OUT special case.
- CALC: one iteration per cycle; the counter ($clog2(XLEN) bits) counts 0..XLEN-1; the last iteration registers the final result and moves to DONE.
- DONE: valid_o=1; on ready_i go to IDLE.
- flush_i in CALC or DONE: next state IDLE, valid_o deasserts, result discarded. flush_i in IDLE blocks acceptance that cycle.
- Multiply:
  - Shift-add on magnitudes into a 2·XLEN product; final conditional negate.
  - Product sign: MUL/MULH = sa^sb; MULHSU = sa; MULHU = 0.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign: sa^sb for DIV; remainder sign: sa for REM; unsigned ops use no sign.
- Special cases, taken regardless of EARLY_OUT (EARLY_OUT only changes latency):
  - b=0: quotient = all ones, remainder = a.
  - Signed DIV/REM with a = 1<<(XLEN-1) and b = all ones: quotient = a, remainder = 0.
- Widths: internal accumulator 2·XLEN+1 bits; no result truncation except explicit selection of the low or high half.

## Timing
- Reset values: state=IDLE, ready_o=1, valid_o=0, result_o=0, counter=0.
- Accept occurs on the rising edge where valid_i & ready_o.
- Normal latency: valid_o rises exactly XLEN cycles after the accepting edge.
- Special-case latency with EARLY_OUT=1: valid_o rises 1 cycle after accept; with EARLY_OUT=0 it is XLEN cycles.
- valid_o and result_o stay stable while valid_o & !ready_i.
- Throughput: a new request can be accepted no earlier than the cycle after the result handshake, because ready_o is low in DONE.
- Reset asserted mid-CALC: immediate return to IDLE with reset values; no stale valid_o after release.
- Simultaneous flush_i and ready_i in DONE: IDLE; identical outcome.

## Structure
- Add to toothless_pkg:
  - md_opcode_e (MD_MUL=3'b000, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU=3'b111).
  - md_state_e.
  - Parameter FUNCT7_MULDIV = 7'b000_0001, used by the decoder to steer R_TYPE ops here.
- Single module; shared shift register/adder for multiply and divide. No sub-module.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB; valid_o exactly 32 cycles after accept.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Special cases:
  - DIVU 0x1234 / 0 → 0xFFFFFFFF; REM 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - All of the above valid 1 cycle after accept with EARLY_OUT=1.
- Backpressure: hold ready_i=0 for 5 cycles in DONE → result_o and valid_o stable, ready_o=0; ready_i=1 → IDLE next cycle.
- Abort and reset:
  - flush_i at CALC cycle 10 → IDLE next cycle, no valid_o; next op MUL 3×4 → 12.
  - rst_ni low mid-CALC → outputs at reset values immediately.

Source files
------------

// File: rtl/toothless_pkg.sv
// toothless_pkg: shared types and constants for the toothless core
package toothless_pkg;
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_opcode_e;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_e;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b000_0001;
endpackage

// File: rtl/toothless_muldiv.sv
// toothless_muldiv: iterative RV32M multiply/divide unit with valid/ready handshakes
module toothless_muldiv
  import toothless_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  md_opcode_e      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  md_state_e       state_q, state_d;
  md_opcode_e      op_q;
  logic [2*XLEN:0] acc_q, acc_d;
  logic [XLEN-1:0] opnd_q;
  logic            neg_q, spec_q;
  logic [CW-1:0]   cnt_q;
  logic            sa, sb, div0, ovf, special, accept, last;
  logic [XLEN-1:0] a_mag, b_mag, spec_res, div_raw, fin;
  logic [XLEN+1:0] add_x, add_y, sum;
  logic [2*XLEN-1:0] prod;
  assign ready_o = state_q == MD_IDLE;
  assign valid_o = state_q == MD_DONE;
  assign accept  = valid_i & ready_o & ~flush_i;
  assign last    = cnt_q == CW'(XLEN - 1);
  // Request decode: operand signs, magnitudes and the two divide special cases
  always_comb begin
    sa       = a_i[XLEN-1] & (op_i inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sb       = b_i[XLEN-1] & (op_i inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
    a_mag    = sa ? -a_i : a_i;
    b_mag    = sb ? -b_i : b_i;
    div0     = op_i[2] && b_i == '0;
    ovf      = (op_i == MD_DIV || op_i == MD_REM) && a_i == {1'b1, {(XLEN-1){1'b0}}} && &b_i;
    special  = div0 | ovf;
    spec_res = div0 ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);
  end
  // One radix-2 step; the single adder adds the multiplicand or subtracts the divisor
  always_comb begin
    add_x   = op_q[2] ? {1'b0, acc_q[2*XLEN-1:XLEN-1]} : {1'b0, acc_q[2*XLEN:XLEN]};
    add_y   = op_q[2] ? ~{2'b0, opnd_q} : (acc_q[0] ? {2'b0, opnd_q} : '0);
    sum     = add_x + add_y + {{(XLEN+1){1'b0}}, op_q[2]};
    acc_d   = !op_q[2] ? {1'b0, sum[XLEN:0], acc_q[XLEN-1:1]} :
              sum[XLEN+1] ? {acc_q[2*XLEN-1:0], 1'b0} : {sum[XLEN:0], acc_q[XLEN-2:0], 1'b1};
    prod    = neg_q ? -acc_d[2*XLEN-1:0] : acc_d[2*XLEN-1:0];
    div_raw = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
    fin     = !op_q[2] ? (op_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
              (neg_q ? -div_raw : div_raw);
  end
  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= MD_IDLE;
    else state_q <= state_d;
  end
  // Next state; flush overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (accept) state_d = (EARLY_OUT && special) ? MD_DONE : MD_CALC;
      MD_CALC: if (last) state_d = MD_DONE;
      MD_DONE: if (ready_i) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
  end
  // Datapath: load on accept, iterate in CALC; special results are written at accept and kept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= MD_MUL;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      cnt_q    <= '0;
      result_o <= '0;
    end else if (accept) begin
      op_q   <= op_i;
      acc_q  <= {{(XLEN+1){1'b0}}, op_i[2] ? a_mag : b_mag};
      opnd_q <= op_i[2] ? b_mag : a_mag;
      neg_q  <= op_i == MD_REM ? sa : sa ^ sb;
      spec_q <= special;
      cnt_q  <= '0;
      if (special) result_o <= spec_res;
    end else if (state_q == MD_CALC && !flush_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      if (last && !spec_q) result_o <= fin;
    end
  end
endmodule

// File: tb/tb_toothless_muldiv.sv
// tb_toothless_muldiv: randomized and directed checks of the multiply/divide unit against an arithmetic model
module tb_toothless_muldiv;
  import toothless_pkg::*;
  localparam int XLEN = 32;
  logic clk_i = 1'b0, rst_ni = 1'b1, valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b0;
  md_opcode_e op_i = MD_MUL;
  logic [XLEN-1:0] a_i = '0, b_i = '0;
  logic ready_o, valid_o;
  logic [XLEN-1:0] result_o;
  int checks = 0, errors = 0;

  toothless_muldiv #(.XLEN(XLEN), .EARLY_OUT(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input md_opcode_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ref_md = '0;
    case (op)
      MD_MUL:    begin p = ua * ub; ref_md = p[31:0]; end
      MD_MULH:   begin p = sa * sb; ref_md = p[63:32]; end
      MD_MULHSU: begin p = sa * ub; ref_md = p[63:32]; end
      MD_MULHU:  begin p = ua * ub; ref_md = p[63:32]; end
      MD_DIV:    ref_md = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      MD_REM:    ref_md = (b == 0) ? a : 32'(sa % sb);
      MD_DIVU:   ref_md = (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REMU:   ref_md = (b == 0) ? a : a % b;
      default:   ref_md = '0;
    endcase
  endfunction

  function automatic bit is_special(input md_opcode_e op, input logic [31:0] a, input logic [31:0] b);
    return (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU} && b == 0) ||
           (op inside {MD_DIV, MD_REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one request, wait for its result, hold it for 'stall' cycles, then take it
  task automatic run(input md_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int stall);
    int lat;
    string t;
    t = $sformatf("%s(%h,%h)", op.name(), a, b);
    @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    chk({t, " ready"}, 64'(ready_o), 64'd1);
    @(posedge clk_i); #1 valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk({t, " latency"}, 64'(lat), is_special(op, a, b) ? 64'd0 : 64'(XLEN));
    chk({t, " result"}, 64'(result_o), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk_i); #1;
      chk({t, " hold"}, {31'b0, valid_o, ready_o, result_o}, {31'b0, 1'b1, 1'b0, exp});
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1 ready_i = 1'b0;
    chk({t, " release"}, {62'b0, valid_o, ready_o}, 64'b01);
  endtask

  initial begin
    int seen, lat;
    md_opcode_e op;
    logic [31:0] a, b;
    int k;
    #2 rst_ni = 1'b0;
    #1;
    chk("reset", {31'b0, valid_o, ready_o, result_o}, {31'b0, 1'b0, 1'b1, 32'h0});
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    run(MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    run(MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    run(MD_DIVU,   32'd100,       32'd7,         32'd14,        0);
    run(MD_REMU,   32'd100,       32'd7,         32'd2,         0);
    run(MD_DIVU,   32'h1234,      32'd0,         32'hFFFF_FFFF, 0);
    run(MD_REM,    32'h1234,      32'd0,         32'h1234,      0);
    run(MD_DIV,    32'hFFFF_FF9C, 32'd0,         32'hFFFF_FFFF, 0);
    run(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0);
    run(MD_MULHU,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 5);

    for (int n = 0; n < 40; n++) begin
      op = md_opcode_e'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0) b = '0;
      else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (k < 4) b = 32'($urandom_range(1, 300));
      run(op, a, b, ref_md(op, a, b), $urandom_range(0, 2));
    end

    @(negedge clk_i);
    op_i = MD_MUL; a_i = 32'd5; b_i = 32'd5; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0; flush_i = 1'b0;
    chk("idle flush blocks accept", 64'(ready_o), 64'd1);

    @(negedge clk_i);
    op_i = MD_MUL; a_i = $urandom; b_i = $urandom; valid_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    chk("calc flush", {62'b0, valid_o, ready_o}, 64'b01);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) seen++;
    end
    chk("no valid after flush", 64'(seen), 64'd0);
    run(MD_MUL, 32'd3, 32'd4, 32'd12, 0);

    @(negedge clk_i);
    op_i = MD_DIVU; a_i = 32'd100; b_i = 32'd7; valid_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("done before flush+ready", 64'(valid_o), 64'd1);
    flush_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0; ready_i = 1'b0;
    chk("flush+ready in done", {62'b0, valid_o, ready_o}, 64'b01);

    @(negedge clk_i);
    op_i = MD_MULH; a_i = $urandom; b_i = $urandom; valid_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    chk("reset mid-calc", {31'b0, valid_o, ready_o, result_o}, {31'b0, 1'b0, 1'b1, 32'h0});
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) seen++;
    end
    chk("no valid after reset", 64'(seen), 64'd0);
    run(MD_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
